word_unpacker: RTL and testbench

WORD_UNPACKER -- requirements
Module: word_unpacker

---
 rtl/word_unpacker_pkg.sv | 17 +
 rtl/word_unpacker.sv | 75 +++++++
 tb/tb_word_unpacker.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/word_unpacker_pkg.sv
// Shared definitions for the word unpacker: widths and FSM state encoding.
package word_unpacker_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_e;

endpackage

// File: rtl/word_unpacker.sv
// Splits 32-bit FIFO words into bytes (MSB first) with a valid/ready handshake.
// Optional last_out flag on the final byte of each word: define WORD_UNPACKER_LAST_EN.
module word_unpacker
  import word_unpacker_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in
`ifdef WORD_UNPACKER_LAST_EN
  ,
  output logic              last_out
`endif
);

  state_e            state_reg, state_next;
  logic [WORD_W-1:0] word_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              handshake;
  logic              last_byte;

  assign handshake = (state_reg == SEND) && ready_in;
  assign last_byte = (idx_reg == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      word_reg  <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == LOAD) begin
        word_reg <= fifo_data;
        idx_reg  <= '0;
      end else if (handshake && !last_byte) begin
        word_reg <= {word_reg[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
        idx_reg  <= idx_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (!fifo_empty) state_next = LOAD;
      LOAD: state_next = SEND;
      SEND: begin
        if (handshake && last_byte) state_next = fifo_empty ? IDLE : LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Only fifo_rd looks at ready_in; the byte outputs come straight from registers.
  always_comb begin
    fifo_rd   = 1'b0;
    valid_out = (state_reg == SEND);
    data_out  = word_reg[WORD_W-1 -: BYTE_W];
    case (state_reg)
      IDLE:    fifo_rd = !fifo_empty;
      SEND:    fifo_rd = handshake && last_byte && !fifo_empty;
      default: fifo_rd = 1'b0;
    endcase
    fifo_rd = fifo_rd && rst_n;
  end

`ifdef WORD_UNPACKER_LAST_EN
  assign last_out = (state_reg == SEND) && last_byte;
`endif

endmodule

// File: tb/tb_word_unpacker.sv
// Self-checking bench for word_unpacker: byte-stream reference model plus directed and random traffic.
module tb_word_unpacker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fifo_data = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        ready_in = 1'b0;
`ifdef WORD_UNPACKER_LAST_EN
  logic        last_out;
`endif

  word_unpacker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in)
`ifdef WORD_UNPACKER_LAST_EN
    ,
    .last_out   (last_out)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int rd_pulses = 0;
  int rd_cyc[$];

  logic [31:0] q[$];        // upstream FIFO contents
  logic [7:0]  m_bq[$];     // model: bytes still to be presented for the current word
  logic        m_inflight = 1'b0;
  logic [31:0] m_word = '0;

  logic [7:0]  acc_log[$];
  int          acc_cyc[$];
  logic [7:0]  last_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    acc_log.delete(); acc_cyc.delete(); last_log.delete(); rd_cyc.delete();
    rd_pulses = 0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic rdy);
    logic exp_v, exp_rd, rd_s;
    ready_in   = rdy;
    fifo_empty = (q.size() == 0);
    #1;
    exp_v  = (m_bq.size() > 0);
    exp_rd = !fifo_empty && ((m_bq.size() == 0 && !m_inflight) || (m_bq.size() == 1 && rdy));
    chk("valid_out", {31'd0, valid_out}, {31'd0, exp_v});
    if (exp_v) chk("data_out", {24'd0, data_out}, {24'd0, m_bq[0]});
    chk("fifo_rd", {31'd0, fifo_rd}, {31'd0, exp_rd});
`ifdef WORD_UNPACKER_LAST_EN
    chk("last_out", {31'd0, last_out}, {31'd0, m_bq.size() == 1});
`endif
    if (valid_out && ready_in) begin
      acc_log.push_back(data_out);
      acc_cyc.push_back(cyc);
      $display("[TB] cycle %0d byte %h accepted", cyc, data_out);
`ifdef WORD_UNPACKER_LAST_EN
      if (last_out) last_log.push_back(data_out);
`endif
    end
    rd_s = fifo_rd;
    if (rd_s) begin rd_pulses++; rd_cyc.push_back(cyc); end
    if (exp_rd && q.size() > 0) m_word = q[0];
    @(posedge clk);
    #1;
    if (rd_s) begin
      if (q.size() == 0) chk("pop_from_empty", 32'd1, 32'd0);
      else fifo_data = q.pop_front();
    end
    if (m_bq.size() > 0 && rdy) void'(m_bq.pop_front());
    if (m_inflight) begin
      for (int b = 3; b >= 0; b--) m_bq.push_back(m_word[b*8 +: 8]);
      m_inflight = 1'b0;
    end
    if (exp_rd) m_inflight = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(rdy);
  endtask

  task automatic reset_now();
    fifo_empty = (q.size() == 0);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_data", {24'd0, data_out}, 32'd0);
    chk("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
`ifdef WORD_UNPACKER_LAST_EN
    chk("rst_last", {31'd0, last_out}, 32'd0);
`endif
    m_bq.delete();
    m_inflight = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_hold_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_hold_fifo_rd", {31'd0, fifo_rd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_log(input string name, input logic [7:0] exp[$]);
    chk({name, "_count"}, acc_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < acc_log.size(); i++)
      chk(name, {24'd0, acc_log[i]}, {24'd0, exp[i]});
  endtask

  initial begin
    logic [7:0] exp_b[$];
    int held;
    int guard;

    // Power-on reset
    @(negedge clk);
    reset_now();

    // Single word
    clear_logs();
    q.push_back(32'hA1B2C3D4);
    run(10, 1'b1);
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    chk_log("single", exp_b);
    if (acc_cyc.size() == 4) begin
      chk("single_latency", acc_cyc[0] - rd_cyc[0], 2);
      chk("single_consec", acc_cyc[3] - acc_cyc[0], 3);
    end
    chk("single_idle_valid", {31'd0, valid_out}, 32'd0);
`ifdef WORD_UNPACKER_LAST_EN
    chk("single_last_n", last_log.size(), 1);
    if (last_log.size() > 0) chk("single_last_b", {24'd0, last_log[0]}, 32'hD4);
`endif

    // Back-to-back words
    clear_logs();
    q.push_back(32'h11223344);
    q.push_back(32'h55667788);
    run(14, 1'b1);
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    chk_log("b2b", exp_b);
    chk("b2b_rd_pulses", rd_pulses, 2);
    if (acc_cyc.size() == 8) begin
      chk("b2b_gap", acc_cyc[4] - acc_cyc[3], 2);
      chk("b2b_throughput", acc_cyc[7] - acc_cyc[0], 8);
    end
`ifdef WORD_UNPACKER_LAST_EN
    chk("b2b_last_n", last_log.size(), 2);
    if (last_log.size() == 2) begin
      chk("b2b_last0", {24'd0, last_log[0]}, 32'h44);
      chk("b2b_last1", {24'd0, last_log[1]}, 32'h88);
    end
`endif

    // Backpressure on B2
    clear_logs();
    q.push_back(32'hA1B2C3D4);
    held = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid_out && data_out == 8'hB2) held++;
      cycle(!(i >= 3 && i <= 5));
    end
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    chk_log("bp", exp_b);
    chk("bp_b2_held", held, 4);

    // Empty FIFO
    clear_logs();
    held = 0;
    for (int i = 0; i < 20; i++) begin
      if (fifo_rd || valid_out) held++;
      cycle(1'(i % 2));
    end
    chk("empty_activity", held, 0);
    chk("empty_rd_pulses", rd_pulses, 0);

    // Reset mid-word
    clear_logs();
    q.push_back(32'hA1B2C3D4);
    q.push_back(32'hDEADBEEF);
    guard = 0;
    while (acc_log.size() < 3 && guard < 20) begin cycle(1'b1); guard++; end
    chk("midrst_reach_c3", {31'd0, acc_log.size() == 3}, 32'd1);
    reset_now();
    run(10, 1'b1);
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    chk_log("midrst", exp_b);

    // Random traffic
    clear_logs();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0 && q.size() < 8) q.push_back($urandom);
      cycle($urandom_range(0, 3) != 0);
    end
    run(60, 1'b1);
    chk("rand_drained_valid", {31'd0, valid_out}, 32'd0);
    chk("rand_fifo_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
